// File: rtl/vedic_pkg.sv
// Shared definitions for the pipelined Vedic partial-product adder: op codes,
// stage count helper and the segment add used by every pipeline stage.
package vedic_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest carry-chain segment the segment helper supports.
  localparam int SEG_MAX_W = 32;

  function automatic int nseg_f(input int a_w, input int seg_w);
    return a_w / seg_w;
  endfunction

  // Operands arrive zero-extended, so the carry out of a w-bit segment is bit w of the result.
  function automatic logic [SEG_MAX_W:0] seg_add(input logic [SEG_MAX_W-1:0] x,
                                                 input logic [SEG_MAX_W-1:0] y,
                                                 input logic               ci);
    return {1'b0, x} + {1'b0, y} + {{SEG_MAX_W{1'b0}}, ci};
  endfunction

endpackage

// File: rtl/vedic_add_seg.sv
// One carry-chain pipeline stage: adds segment LO_W +: SEG_W, registers sum and carry,
// and carries the finished lower result bits and the not-yet-added upper operand bits.
module vedic_add_seg
  import vedic_pkg::*;
#(
  parameter int SEG_W = 4,
  parameter int LO_W  = 0,
  parameter int HI_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        adv,
  input  logic [LO_W+SEG_W+HI_W-1:0]  s_i,
  input  logic [LO_W+SEG_W+HI_W-1:0]  a_i,
  input  logic [LO_W+SEG_W+HI_W-1:0]  bx_i,
  input  logic                        c_i,
  output logic                        v_o,
  output logic [LO_W+SEG_W+HI_W-1:0]  s_o,
  output logic [LO_W+SEG_W+HI_W-1:0]  a_o,
  output logic [LO_W+SEG_W+HI_W-1:0]  bx_o,
  output logic                        c_o
);

  localparam int W = LO_W + SEG_W + HI_W;
  localparam logic [W-1:0] LO_MASK = {W{1'b1}} >> (W - LO_W);
  localparam logic [W-1:0] HI_MASK = {W{1'b1}} << (LO_W + SEG_W);

  logic           v_q, v_d;
  logic           c_q, c_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   bx_q, bx_d;
  logic [SEG_W:0] sum_w;

  always_comb begin
    sum_w = (SEG_W+1)'(seg_add(SEG_MAX_W'(a_i[LO_W +: SEG_W]),
                               SEG_MAX_W'(bx_i[LO_W +: SEG_W]), c_i));
    v_d  = v_q;
    c_d  = c_q;
    s_d  = s_q;
    a_d  = a_q;
    bx_d = bx_q;
    if (load) begin
      v_d  = 1'b1;
      c_d  = sum_w[SEG_W];
      s_d  = (s_i & LO_MASK) | (W'(sum_w[SEG_W-1:0]) << LO_W);
      a_d  = a_i & HI_MASK;
      bx_d = bx_i & HI_MASK;
    end else if (adv) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= 1'b0;
      c_q  <= 1'b0;
      s_q  <= '0;
      a_q  <= '0;
      bx_q <= '0;
    end else begin
      v_q  <= v_d;
      c_q  <= c_d;
      s_q  <= s_d;
      a_q  <= a_d;
      bx_q <= bx_d;
    end
  end

  assign v_o  = v_q;
  assign c_o  = c_q;
  assign s_o  = s_q;
  assign a_o  = a_q;
  assign bx_o = bx_q;

endmodule

// File: rtl/vedic_add_pipe.sv
// Pipelined unequal-width adder/subtractor: the carry chain is cut into SEG_W-bit
// segments with one register stage each, so results appear NSEG cycles after acceptance.
module vedic_add_pipe
  import vedic_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int B_W   = 4,
  parameter int SEG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] s,
  output logic           cout
);

  localparam int NSEG = nseg_f(A_W, SEG_W);

  if (A_W % SEG_W != 0) begin : g_bad_seg_w
    $error("vedic_add_pipe: A_W must be a multiple of SEG_W");
  end
  if (B_W > A_W) begin : g_bad_b_w
    $error("vedic_add_pipe: B_W must not exceed A_W");
  end
  if (SEG_W > SEG_MAX_W) begin : g_bad_seg_max
    $error("vedic_add_pipe: SEG_W exceeds SEG_MAX_W");
  end

  logic [A_W-1:0]            bx;
  logic [NSEG:0][A_W-1:0]    s_c;
  logic [NSEG:0]             c_c;
  logic [NSEG-1:0][A_W-1:0]  a_c, bx_c;
  logic [NSEG-1:0][A_W-1:0]  a_n, bx_n;
  logic [NSEG-1:0]           v, load, adv, free;
  logic [A_W-1:0]            unused_a_tail, unused_bx_tail;

  assign bx      = A_W'(b);
  assign s_c[0]  = '0;
  assign a_c[0]  = a;
  assign bx_c[0] = (sub == OP_SUB) ? ~bx : bx;
  assign c_c[0]  = (sub == OP_ADD) ? 1'b0 : 1'b1;

  // Handshake: a transfer happens on valid && ready at either end. Stage k is free when it
  // is empty or advancing into stage k+1 (the last stage advances on out_ready), so bubbles
  // collapse under stall. in_ready depends on out_ready and stage valids, never on in_valid.
  always_comb begin
    adv  = '0;
    free = '0;
    load = '0;
    adv[NSEG-1]  = v[NSEG-1] && out_ready;
    free[NSEG-1] = !v[NSEG-1] || out_ready;
    for (int k = NSEG - 2; k >= 0; k--) begin
      adv[k]  = v[k] && free[k+1];
      free[k] = !v[k] || adv[k];
    end
    load[0] = in_valid && free[0];
    for (int k = 1; k < NSEG; k++) begin
      load[k] = v[k-1] && free[k];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    vedic_add_seg #(
      .SEG_W (SEG_W),
      .LO_W  (k * SEG_W),
      .HI_W  (A_W - (k + 1) * SEG_W)
    ) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .adv   (adv[k]),
      .s_i   (s_c[k]),
      .a_i   (a_c[k]),
      .bx_i  (bx_c[k]),
      .c_i   (c_c[k]),
      .v_o   (v[k]),
      .s_o   (s_c[k+1]),
      .a_o   (a_n[k]),
      .bx_o  (bx_n[k]),
      .c_o   (c_c[k+1])
    );
    if (k < NSEG - 1) begin : g_fwd
      assign a_c[k+1]  = a_n[k];
      assign bx_c[k+1] = bx_n[k];
    end
  end

  // The last stage has no upper operand bits left to forward.
  assign unused_a_tail  = a_n[NSEG-1];
  assign unused_bx_tail = bx_n[NSEG-1];

  assign in_ready  = free[0];
  assign out_valid = v[NSEG-1];
  assign s         = s_c[NSEG];
  assign cout      = c_c[NSEG];

endmodule

// File: tb/tb_vedic_add_pipe.sv
// Directed bench for vedic_add_pipe: default 8/4/4 instance plus a 16/8/4 instance.
module tb_vedic_add_pipe;
  import vedic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       in_valid, in_ready, sub, out_valid, out_ready, cout;
  logic [7:0] a, s;
  logic [3:0] b;

  logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, s16;
  logic [7:0]  b16;

  vedic_add_pipe #(.A_W(8), .B_W(4), .SEG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
  );

  vedic_add_pipe #(.A_W(16), .B_W(8), .SEG_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
    .s(s16), .cout(cout16)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  // streaming vectors: expected value is {cout, s}
  logic [7:0] st_a   [16] = '{8'h12, 8'h80, 8'hFE, 8'h03, 8'h55, 8'hAA, 8'hF8, 8'h00,
                              8'h7F, 8'h01, 8'h3C, 8'hC0, 8'hFF, 8'hFF, 8'h0E, 8'h10};
  logic [3:0] st_b   [16] = '{4'h3, 4'h5, 4'hF, 4'h7, 4'hA, 4'hA, 4'h8, 4'h0,
                              4'h1, 4'hF, 4'h4, 4'h1, 4'h0, 4'hF, 4'h2, 4'h0};
  logic       st_sub [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [8:0] st_e   [16] = '{9'h015, 9'h17B, 9'h10D, 9'h0FC, 9'h05F, 9'h1A0, 9'h100, 9'h100,
                              9'h080, 9'h0F2, 9'h040, 9'h1BF, 9'h0FF, 9'h1F0, 9'h010, 9'h110};

  logic [7:0] bp_a   [4] = '{8'h11, 8'h20, 8'hF0, 8'h05};
  logic [3:0] bp_b   [4] = '{4'h1, 4'h3, 4'hF, 4'h3};
  logic       bp_sub [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [8:0] bp_e   [4] = '{9'h012, 9'h11D, 9'h0FF, 9'h102};

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] aa, input logic [3:0] bb, input logic ss);
    a = aa; b = bb; sub = ss; in_valid = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = OP_ADD; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = OP_ADD; out_ready16 = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (s !== 8'h00) begin bad++; $display("FAIL reset_s: got %h want 00", s); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16: got %b want 0", out_valid16); end
    rst_n = 1'b1;
    tick();
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL reset_release: got rdy/vld %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    drive(8'hFF, 4'h1, OP_ADD);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_wrap_early: got out_valid %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_wrap_valid: got %b want 1", out_valid); end
    total++; if ({cout, s} !== 9'h100) begin bad++; $display("FAIL add_wrap_result: got %h want 100", {cout, s}); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_wrap_single: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive(8'h10, 4'h1, OP_SUB);
    tick();
    drive(8'h00, 4'h1, OP_SUB);
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, cout, s} !== 10'b1_1_0000_1111) begin bad++; $display("FAIL sub_no_borrow: got %b want 1100001111", {out_valid, cout, s}); end
    tick();
    total++; if ({out_valid, cout, s} !== 10'b1_0_1111_1111) begin bad++; $display("FAIL sub_borrow: got %b want 1011111111", {out_valid, cout, s}); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_drained: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_cross_carry();
    out_ready = 1'b1;
    drive(8'h0F, 4'h1, OP_ADD);
    tick();
    in_valid = 1'b0;
    tick();
    total++; if ({out_valid, cout, s} !== 10'b1_0_0001_0000) begin bad++; $display("FAIL cross_carry: got %b want 1000010000", {out_valid, cout, s}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    int stalls = 0;
    logic [8:0] e;
    out_ready = 1'b1;
    exp_q.delete();
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (idx < 16) drive(st_a[idx], st_b[idx], st_sub[idx]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got %h with nothing expected", {cout, s});
        end else begin
          e = exp_q.pop_front();
          if ({cout, s} !== e) begin bad++; $display("FAIL stream_result %0d: got %h want %h", got, {cout, s}, e); end
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        exp_q.push_back(st_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++; if (got != 16) begin bad++; $display("FAIL stream_count: got %0d want 16", got); end
    total++; if (last - first != 15) begin bad++; $display("FAIL stream_consecutive: got span %0d want 15", last - first); end
    total++; if (stalls != 0) begin bad++; $display("FAIL stream_in_ready: got %0d stall cycles want 0", stalls); end
    total++; if (first != 2) begin bad++; $display("FAIL stream_latency: got first output cycle %0d want 2", first); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    logic [8:0] e;
    exp_q.delete();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (idx < 4) drive(bp_a[idx], bp_b[idx], bp_sub[idx]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (cyc >= 2) begin
        total++;
        if ({in_ready, out_valid, cout, s} !== 11'b0_1_0_0001_0010) begin
          bad++; $display("FAIL bp_stall cyc %0d: got rdy/vld/c/s %b want 01000010010", cyc, {in_ready, out_valid, cout, s});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    total++; if (idx != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idx < 4) drive(bp_a[idx], bp_b[idx], bp_sub[idx]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h with nothing expected", {cout, s});
        end else begin
          e = exp_q.pop_front();
          if ({cout, s} !== e) begin bad++; $display("FAIL bp_result %0d: got %h want %h", got, {cout, s}, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL bp_drain_count: got %0d want 4", got); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_flight();
    int stale = 0;
    out_ready = 1'b0;
    drive(8'h33, 4'h2, OP_ADD);
    tick();
    drive(8'h44, 4'h1, OP_SUB);
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, cout, s} !== 10'b1_0_0011_0101) begin bad++; $display("FAIL rst_pre: got %b want 1000110101", {out_valid, cout, s}); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    total++; if (s !== 8'h00) begin bad++; $display("FAIL rst_mid_s: got %h want 00", s); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rst_mid_cout: got %b want 0", cout); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rst_stale: got %0d valid cycles want 0", stale); end
    drive(8'h01, 4'h1, OP_ADD);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_next_early: got %b want 0", out_valid); end
    tick();
    total++; if ({out_valid, cout, s} !== 10'b1_0_0000_0010) begin bad++; $display("FAIL rst_next_result: got %b want 1000000010", {out_valid, cout, s}); end
    tick();
  endtask

  task automatic test_param_sweep();
    int lat;
    out_ready16 = 1'b1;
    a16 = 16'hFFFF; b16 = 8'h01; sub16 = OP_ADD; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 10) begin tick(); lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL sweep_add_latency: got %0d want 4", lat); end
    total++; if ({cout16, s16} !== 17'h10000) begin bad++; $display("FAIL sweep_add_result: got %h want 10000", {cout16, s16}); end
    tick();
    a16 = 16'h1234; b16 = 8'h35; sub16 = OP_SUB; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 10) begin tick(); lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL sweep_sub_latency: got %0d want 4", lat); end
    total++; if ({cout16, s16} !== 17'h111FF) begin bad++; $display("FAIL sweep_sub_result: got %h want 111FF", {cout16, s16}); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_cross_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_flight();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
